// File: rtl/axi_slave_eeprom_rd_bridge.sv
// AXI4 read-only slave window onto an I2C EEPROM: each read beat is one random byte read.
// Optional I2C_TIMEOUT_EN builds a 20-bit watchdog that fills a stuck beat with 8'hFF / SLVERR.
module axi_slave_eeprom_rd_bridge #(
    parameter logic [7:0] BASE_ADDR_HI = 8'h30,
    parameter int         ID_W         = 2
) (
    input  logic            clk,
    input  logic            dma_rstn_sync,
    input  logic [ID_W-1:0] SLAVE_RD_ADDR_ID,
    input  logic [31:0]     SLAVE_RD_ADDR,
    input  logic [7:0]      SLAVE_RD_ADDR_LEN,
    input  logic [1:0]      SLAVE_RD_ADDR_BURST,
    input  logic            SLAVE_RD_ADDR_VALID,
    output logic            SLAVE_RD_ADDR_READY,
    output logic [ID_W-1:0] SLAVE_RD_BACK_ID,
    output logic [31:0]     SLAVE_RD_DATA,
    output logic [1:0]      SLAVE_RD_DATA_RESP,
    output logic            SLAVE_RD_DATA_LAST,
    output logic            SLAVE_RD_DATA_VALID,
    input  logic            SLAVE_RD_DATA_READY,
    input  logic [ID_W-1:0] SLAVE_WR_ADDR_ID,
    input  logic [31:0]     SLAVE_WR_ADDR,
    input  logic [7:0]      SLAVE_WR_ADDR_LEN,
    input  logic [1:0]      SLAVE_WR_ADDR_BURST,
    input  logic            SLAVE_WR_ADDR_VALID,
    output logic            SLAVE_WR_ADDR_READY,
    input  logic [31:0]     SLAVE_WR_DATA,
    input  logic [3:0]      SLAVE_WR_STRB,
    input  logic            SLAVE_WR_DATA_LAST,
    input  logic            SLAVE_WR_DATA_VALID,
    output logic            SLAVE_WR_DATA_READY,
    output logic [ID_W-1:0] SLAVE_WR_BACK_ID,
    output logic [1:0]      SLAVE_WR_BACK_RESP,
    output logic            SLAVE_WR_BACK_VALID,
    input  logic            SLAVE_WR_BACK_READY,
    output logic            i2c_req,
    output logic [6:0]      i2c_dev_addr,
    output logic            i2c_addr16_en,
    output logic [15:0]     i2c_mem_addr,
    input  logic            i2c_ack,
    input  logic [7:0]      i2c_rdata,
    input  logic            i2c_nack
);
    localparam logic [1:0] R_IDLE = 2'd0, R_REQ = 2'd1, R_DATA = 2'd2;
    localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;

    logic [1:0]      rstate, wstate;
    logic [ID_W-1:0] r_id, w_id;
    logic [6:0]      r_dev;
    logic            r_en16, r_miss, w_miss;
    logic [15:0]     r_off;
    logic [7:0]      r_len, r_cnt, r_byte;
    logic [1:0]      r_burst, r_resp;
`ifdef I2C_TIMEOUT_EN
    logic [19:0]     tmo_cnt;
`endif

    always_ff @(posedge clk or negedge dma_rstn_sync) begin
        if (!dma_rstn_sync) begin
            rstate  <= R_IDLE;
            r_id    <= '0;
            r_dev   <= '0;
            r_en16  <= 1'b0;
            r_off   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_burst <= '0;
            r_miss  <= 1'b0;
            r_byte  <= '0;
            r_resp  <= '0;
`ifdef I2C_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
        end else begin
            case (rstate)
                R_IDLE: if (SLAVE_RD_ADDR_VALID) begin
                    r_id    <= SLAVE_RD_ADDR_ID;
                    r_dev   <= SLAVE_RD_ADDR[23:17];
                    r_en16  <= SLAVE_RD_ADDR[16];
                    r_off   <= SLAVE_RD_ADDR[15:0];
                    r_len   <= SLAVE_RD_ADDR_LEN;
                    r_burst <= SLAVE_RD_ADDR_BURST;
                    r_cnt   <= '0;
                    r_miss  <= (SLAVE_RD_ADDR[31:24] != BASE_ADDR_HI);
`ifdef I2C_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    rstate  <= R_REQ;
                end
                R_REQ: begin
                    // A base miss never touches the bus: answer DECERR straight away.
                    if (r_miss) begin
                        r_byte <= '0;
                        r_resp <= 2'b11;
                        rstate <= R_DATA;
                    end else if (i2c_ack) begin
                        r_byte <= i2c_rdata;
                        r_resp <= i2c_nack ? 2'b10 : 2'b00;
                        rstate <= R_DATA;
                    end
`ifdef I2C_TIMEOUT_EN
                    else if (tmo_cnt == 20'hFFFFF) begin
                        r_byte <= 8'hFF;
                        r_resp <= 2'b10;
                        rstate <= R_DATA;
                    end else begin
                        tmo_cnt <= tmo_cnt + 20'd1;
                    end
`endif
                end
                R_DATA: if (SLAVE_RD_DATA_READY) begin
                    if (r_cnt == r_len) begin
                        rstate <= R_IDLE;
                    end else begin
                        // FIXED bursts re-read the same byte; the 16-bit offset wraps.
                        r_cnt  <= r_cnt + 8'd1;
                        r_off  <= r_off + {15'd0, (r_burst != 2'b00)};
`ifdef I2C_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                        rstate <= R_REQ;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    assign SLAVE_RD_ADDR_READY = (rstate == R_IDLE);
    assign SLAVE_RD_DATA_VALID = (rstate == R_DATA);
    assign SLAVE_RD_DATA_LAST  = (rstate == R_DATA) && (r_cnt == r_len);
    assign SLAVE_RD_BACK_ID    = r_id;
    assign SLAVE_RD_DATA       = {24'h0, r_byte};
    assign SLAVE_RD_DATA_RESP  = r_resp;
    assign i2c_req             = (rstate == R_REQ) && !r_miss;
    assign i2c_dev_addr        = r_dev;
    assign i2c_addr16_en       = r_en16;
    assign i2c_mem_addr        = r_off;

    always_ff @(posedge clk or negedge dma_rstn_sync) begin
        if (!dma_rstn_sync) begin
            wstate <= W_IDLE;
            w_id   <= '0;
            w_miss <= 1'b0;
        end else begin
            case (wstate)
                W_IDLE: if (SLAVE_WR_ADDR_VALID) begin
                    w_id   <= SLAVE_WR_ADDR_ID;
                    w_miss <= (SLAVE_WR_ADDR[31:24] != BASE_ADDR_HI);
                    wstate <= W_DATA;
                end
                W_DATA: if (SLAVE_WR_DATA_VALID && SLAVE_WR_DATA_LAST) wstate <= W_RESP;
                W_RESP: if (SLAVE_WR_BACK_READY) wstate <= W_IDLE;
                default: wstate <= W_IDLE;
            endcase
        end
    end

    assign SLAVE_WR_ADDR_READY = (wstate == W_IDLE);
    assign SLAVE_WR_DATA_READY = (wstate == W_DATA);
    assign SLAVE_WR_BACK_VALID = (wstate == W_RESP);
    assign SLAVE_WR_BACK_ID    = w_id;
    assign SLAVE_WR_BACK_RESP  = (wstate == W_RESP) ? (w_miss ? 2'b11 : 2'b10) : 2'b00;

    // Write payload is drained without being looked at.
    logic unused_ok;
    assign unused_ok = ^{SLAVE_WR_ADDR[23:0], SLAVE_WR_ADDR_LEN, SLAVE_WR_ADDR_BURST,
                         SLAVE_WR_DATA, SLAVE_WR_STRB};
endmodule

// File: doc/axi_slave_eeprom_rd_bridge.md
Name: axi_slave_eeprom_rd_bridge

Overview:
- AXI4 slave at I2C_EEPROM_SLAVE_BASEADDR. It serves the boot master's EEPROM reads (IP/MAC fetch) and any later host reads in that window.
- Each read beat becomes one single-byte random read on a downstream I2C byte engine. The byte is returned in RDATA[7:0].
- Writes are drained and refused, so the EEPROM is read-only on this path.

Parameters:
- BASE_ADDR_HI, 8'h30: required value of ARADDR[31:24] / AWADDR[31:24].
- ID_W, 2: AXI ID width.

Ports:
- clk  in  1  clock.
- dma_rstn_sync  in  1  reset, asynchronous, active-low.
- SLAVE_RD_ADDR_ID  in  ID_W  AR ID.
- SLAVE_RD_ADDR  in  32  AR address:
  - [31:24] base
  - [23:17] I2C device address
  - [16] 16-bit word-address enable
  - [15:0] byte offset
- SLAVE_RD_ADDR_LEN  in  8  beats-1.
- SLAVE_RD_ADDR_BURST  in  2  00 FIXED, 01 INCR, 10/11 treated as INCR.
- SLAVE_RD_ADDR_VALID / SLAVE_RD_ADDR_READY  in/out  1  AR handshake.
- SLAVE_RD_BACK_ID  out  ID_W  echoed AR ID.
- SLAVE_RD_DATA  out  32  {24'h0, byte}.
- SLAVE_RD_DATA_RESP  out  2  per-beat response.
- SLAVE_RD_DATA_LAST  out  1  final beat.
- SLAVE_RD_DATA_VALID / SLAVE_RD_DATA_READY  out/in  1  R handshake.
- SLAVE_WR_ADDR_ID, SLAVE_WR_ADDR, SLAVE_WR_ADDR_LEN, SLAVE_WR_ADDR_BURST, SLAVE_WR_ADDR_VALID / SLAVE_WR_ADDR_READY  in/out  AW channel (widths as AR).
- SLAVE_WR_DATA  in  32;  SLAVE_WR_STRB  in  4;  SLAVE_WR_DATA_LAST  in  1;  SLAVE_WR_DATA_VALID / SLAVE_WR_DATA_READY  in/out  1  W channel.
- SLAVE_WR_BACK_ID  out  ID_W;  SLAVE_WR_BACK_RESP  out  2;  SLAVE_WR_BACK_VALID / SLAVE_WR_BACK_READY  out/in  1  B channel.
- i2c_req  out  1  byte-read request, held until i2c_ack.
- i2c_dev_addr  out  7;  i2c_addr16_en  out  1;  i2c_mem_addr  out  16.
- i2c_ack  in  1  one-cycle completion pulse.
- i2c_rdata  in  8  valid with i2c_ack.
- i2c_nack  in  1  valid with i2c_ack; device NACKed.

Behaviour:
- Reset values: every VALID, READY, LAST, BACK_* and i2c_* output is 0.
  - Exception: SLAVE_RD_ADDR_READY = 1 and SLAVE_WR_ADDR_READY = 1 out of reset, since both FSMs reset to their idle states.
- Read FSM states: R_IDLE, R_REQ, R_DATA.
  - R_IDLE: ARREADY = 1. On AR handshake, latch ID, dev, en16, offset, len, burst; clear beat_cnt; set miss = (ARADDR[31:24] != BASE_ADDR_HI); go to R_REQ.
  - R_REQ: i2c_req = !miss, with address outputs stable for the whole request.
    - On i2c_ack: capture rdata; RESP = i2c_nack ? 2'b10 : 2'b00; go to R_DATA.
    - If miss: go to R_DATA in the next cycle with data 0 and RESP 2'b11, no I2C activity.
  - R_DATA: RVALID = 1; RLAST = (beat_cnt == len); RDATA and RESP held until RREADY.
    - On handshake with LAST: go to R_IDLE.
    - Otherwise: beat_cnt++, offset += (burst != 00), then go to R_REQ.
  - Offset wraps 16'hFFFF -> 16'h0000. The device field is never modified.
- Latency: AR handshake -> i2c_req after 1 cycle; i2c_ack -> RVALID after 1 cycle; RREADY handshake -> next i2c_req after 1 cycle.
- An NACK on a beat does not abort the burst; the remaining beats are still attempted.
- Write FSM states: W_IDLE, W_DATA, W_RESP. It is independent of the read FSM.
  - W_IDLE: AWREADY = 1; latch ID.
  - W_DATA: WREADY = 1; discard beats until WLAST.
  - W_RESP: BVALID = 1, BRESP = 2'b10, or 2'b11 on base miss; leave on BREADY.
- Simultaneous AR and AW are both accepted in the same cycle.
- Async reset mid-burst: all FSMs return to idle immediately and i2c_req drops. The I2C engine tolerates an abandoned request. No partial R/B beat is emitted after reset.

Optional Feature:
- Macro I2C_TIMEOUT_EN.
- Defined: 20-bit counter runs in R_REQ and clears on entry. If it reaches 20'hFFFFF without i2c_ack, drop i2c_req and produce a beat with data 8'hFF and RESP 2'b10, then continue the burst.
- Undefined: R_REQ waits for i2c_ack indefinitely; no counter is built.

Test Plan:
- AR addr=32'h30A7_0000, len=3, INCR; engine returns C0, A8, 01, 64 -> 4 beats RDATA 0xC0, 0xA8, 0x01, 0x64; RESP 00; LAST on beat 3 only; i2c_mem_addr 0, 1, 2, 3; dev 7'h53; en16 = 1.
- Same AR with burst=00, len=1 -> i2c_mem_addr stays 0x0000 for both beats.
- AR addr=32'h30A6_FFFF, len=1, INCR -> mem_addr 0xFFFF then 0x0000; en16 = 0.
- AR addr=32'h20A7_0000, len=2 -> 3 beats, data 0, RESP 11, i2c_req never asserted.
- NACK on beat 1 of a len=2 burst -> RESP 00, 10, 00; all 3 beats returned.
- AW + 2 W beats concurrent with a read -> BRESP 10 after WLAST. Assert dma_rstn_sync low during the read's R_REQ -> i2c_req drops in the same cycle and the next AR is served normally.
- With I2C_TIMEOUT_EN defined and no ack: RVALID after 2^20-1 cycles, data 0xFF, RESP 10.
